// File: rtl/counter_up_8b.sv
// Up counter: counts 0..target after a load, then parks in DONE.
// Elapsed-cycle companion to the down counter.
module counter_up_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] target_n;
  logic [WIDTH-1:0] count_inc;
  logic             step;

  assign count_inc = count + WIDTH'(1);
  assign step      = !load && en && (state == S_COUNT);

  // Next-state decode: load wins, then an enabled step, else hold.
  always_comb begin
    state_n  = state;
    count_n  = count;
    target_n = target;
    unique case (1'b1)
      load: begin
        target_n = in;
        count_n  = '0;
        state_n  = (in == '0) ? S_DONE : S_COUNT;
      end
      step: begin
        count_n = count_inc;
        state_n = (count_inc == target) ? S_DONE : S_COUNT;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      count  <= '0;
      target <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      target <= target_n;
    end
  end

  assign busy = (state == S_COUNT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_counter_up_8b.sv
// Scoreboard bench for counter_up_8b.
// Outputs are sampled 1 time unit before each rising edge.
module tb_counter_up_8b;

  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       d;
  } exp_t;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
    logic       e;
    logic [7:0] c;
    logic       b;
    logic       dn;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] in;
  logic       en;
  logic [7:0] count;
  logic       busy;
  logic       done;

  exp_t exp_q [$];
  int   vectors = 0;
  int   fails   = 0;

  counter_up_8b dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .in    (in),
    .en    (en),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic l, input logic [7:0] d,
                       input logic e, input exp_t x);
    load = l;
    in   = d;
    en   = e;
    exp_q.push_back(x);
    @(posedge clk);
    #9;
  endtask

  task automatic test_reset();
    exp_t got, want;
    rst  = 1'b0;
    load = 1'b0;
    in   = 8'h00;
    en   = 1'b0;
    #4;
    exp_q.push_back(10'h000);
    want = exp_q.pop_front();
    got  = '{count, busy, done};
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset: got %h want %h", got, want);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h5A, 1'b1, 10'h000);
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL idle %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  task automatic test_basic();
    vec_t t [6] = '{
      '{1'b1, 8'd3,   1'b0, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'hA5,  1'b1, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'h00,  1'b1, 8'd2, 1'b1, 1'b0},
      '{1'b0, 8'hFF,  1'b1, 8'd3, 1'b0, 1'b1},
      '{1'b0, 8'h01,  1'b1, 8'd3, 1'b0, 1'b1},
      '{1'b0, 8'h07,  1'b0, 8'd3, 1'b0, 1'b1}
    };
    exp_t got, want;
    for (int i = 0; i < 6; i++) begin
      drive(t[i].l, t[i].d, t[i].e, '{t[i].c, t[i].b, t[i].dn});
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL basic %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  task automatic test_zero_max();
    exp_t got, want;
    exp_t x;
    for (int i = 0; i < 259; i++) begin
      if (i == 0) begin
        drive(1'b1, 8'd0, 1'b1, '{8'd0, 1'b0, 1'b1});
      end else if (i == 1) begin
        drive(1'b0, 8'd9, 1'b1, '{8'd0, 1'b0, 1'b1});
      end else if (i == 2) begin
        drive(1'b1, 8'd255, 1'b1, '{8'd0, 1'b1, 1'b0});
      end else begin
        x.c = (i - 2 > 255) ? 8'd255 : 8'(i - 2);
        x.b = (i - 2 < 255);
        x.d = (i - 2 >= 255);
        drive(1'b0, 8'($urandom_range(255)), 1'b1, x);
      end
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL zero_max %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  task automatic test_enable();
    vec_t t [8] = '{
      '{1'b1, 8'd4,  1'b1, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'h11, 1'b1, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'h22, 1'b0, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'h33, 1'b0, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'h44, 1'b1, 8'd2, 1'b1, 1'b0},
      '{1'b0, 8'h55, 1'b1, 8'd3, 1'b1, 1'b0},
      '{1'b0, 8'h66, 1'b1, 8'd4, 1'b0, 1'b1},
      '{1'b0, 8'h77, 1'b1, 8'd4, 1'b0, 1'b1}
    };
    exp_t got, want;
    for (int i = 0; i < 8; i++) begin
      drive(t[i].l, t[i].d, t[i].e, '{t[i].c, t[i].b, t[i].dn});
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL enable %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t [9] = '{
      '{1'b1, 8'd5,  1'b1, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'd0,  1'b1, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'd0,  1'b1, 8'd2, 1'b1, 1'b0},
      '{1'b1, 8'd2,  1'b1, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'd0,  1'b1, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'd0,  1'b1, 8'd2, 1'b0, 1'b1},
      '{1'b1, 8'd7,  1'b1, 8'd0, 1'b1, 1'b0},
      '{1'b1, 8'd1,  1'b1, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'd0,  1'b1, 8'd1, 1'b0, 1'b1}
    };
    exp_t got, want;
    for (int i = 0; i < 9; i++) begin
      drive(t[i].l, t[i].d, t[i].e, '{t[i].c, t[i].b, t[i].dn});
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL b2b %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t t [8] = '{
      '{1'b1, 8'd9, 1'b0, 8'd0, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd4, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b0, 8'd4, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0}
    };
    exp_t got, want;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        #4;
        rst = 1'b0;
        #1;
        exp_q.push_back(10'h000);
        want = exp_q.pop_front();
        got  = '{count, busy, done};
        vectors++;
        if (got !== want) begin
          fails++;
          $display("FAIL async_rst: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                   got.c, got.b, got.d, want.c, want.b, want.d);
        end
        #2;
        rst = 1'b1;
        #2;
      end
      drive(t[i].l, t[i].d, t[i].e, '{t[i].c, t[i].b, t[i].dn});
      want = exp_q.pop_front();
      got  = '{count, busy, done};
      vectors++;
      if (got !== want) begin
        fails++;
        $display("FAIL async %0d: got c=%0d b=%0b d=%0b want c=%0d b=%0b d=%0b",
                 i, got.c, got.b, got.d, want.c, want.b, want.d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_max();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
